// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: prefetches aligned 32-bit words from the I-cache into a
// halfword-granular circular queue. It realigns 16/32-bit RV32IC instructions
// and issues one instruction per cycle to ID on a valid/ready handshake.
module riscv_fetch_queue #(
    parameter int unsigned FQ_DEPTH = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ICACHE_ren,
    output logic        ICACHE_wen,
    output logic [29:0] ICACHE_addr,
    output logic [31:0] ICACHE_wdata,
    input  logic        ICACHE_stall,
    input  logic [31:0] ICACHE_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_compressed
);

    localparam int unsigned    PTR_W   = $clog2(FQ_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FQ_DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] TWO_C   = (PTR_W + 1)'(2);

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [15:0]      fq_mem [FQ_DEPTH];
    logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
    logic [PTR_W:0]   count, free_cnt, push_cnt, pop_cnt;
    logic [31:0]      head_pc, pop_bytes;
    logic [29:0]      fetch_addr, drop_addr;
    logic             skip_lo, pend;
    logic             push_en, pop_en, is_comp;
    logic [15:0]      half0, half1;
    logic             unused_pc_bit;

    assign unused_pc_bit = redirect_pc[0];

    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = '0;

    assign head_nxt = head + PTR_W'(1);
    assign tail_nxt = tail + PTR_W'(1);
    assign half0    = fq_mem[head];
    assign half1    = fq_mem[head_nxt];
    assign is_comp  = (half0[1:0] != 2'b11);
    assign free_cnt = DEPTH_C - count;

    // Fetch request, response routing, head decode and FSM next state.
    always_comb begin
        ICACHE_ren     = 1'b0;
        ICACHE_addr    = fetch_addr;
        state_next     = state;
        push_en        = 1'b0;
        pop_en         = 1'b0;
        push_cnt       = '0;
        pop_cnt        = '0;
        pop_bytes      = 32'd0;
        out_valid      = 1'b0;
        out_inst       = '0;
        out_pc         = RESET_PC;
        out_compressed = 1'b0;

        if (rst_n) begin
            // DROP keeps presenting the abandoned miss until the cache lets go.
            if (state == DROP) begin
                ICACHE_ren  = 1'b1;
                ICACHE_addr = drop_addr;
            end else begin
                ICACHE_ren = pend || (free_cnt >= TWO_C);
            end

            case (state)
                FETCH: if (redirect_valid && ICACHE_ren && ICACHE_stall) state_next = DROP;
                DROP:  if (!ICACHE_stall) state_next = FETCH;
                default: state_next = FETCH;
            endcase

            push_en = (state == FETCH) && ICACHE_ren && !ICACHE_stall && !redirect_valid;
            if (push_en) push_cnt = skip_lo ? ONE_C : TWO_C;

            out_valid      = ((count != '0) && is_comp) || (count >= TWO_C);
            out_inst       = is_comp ? {16'h0000, half0} : {half1, half0};
            out_pc         = head_pc;
            out_compressed = is_comp;

            pop_en = out_valid && out_ready && !redirect_valid;
            if (pop_en) begin
                pop_cnt   = is_comp ? ONE_C : TWO_C;
                pop_bytes = is_comp ? 32'd2 : 32'd4;
            end
        end
    end

    // Control state: pointers, occupancy, PCs, skip flag and FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            pend       <= 1'b0;
            drop_addr  <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            head_pc    <= RESET_PC;
            fetch_addr <= RESET_PC[31:2];
            skip_lo    <= RESET_PC[1];
        end else begin
            state <= state_next;
            pend  <= ICACHE_ren && ICACHE_stall;
            if ((state == FETCH) && (state_next == DROP)) drop_addr <= fetch_addr;

            if (redirect_valid) begin
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                head_pc    <= {redirect_pc[31:1], 1'b0};
                fetch_addr <= redirect_pc[31:2];
                skip_lo    <= redirect_pc[1];
            end else begin
                if (push_en) begin
                    tail       <= tail + push_cnt[PTR_W-1:0];
                    fetch_addr <= fetch_addr + 30'd1;
                    skip_lo    <= 1'b0;
                end
                if (pop_en) begin
                    head    <= head + pop_cnt[PTR_W-1:0];
                    head_pc <= head_pc + pop_bytes;
                end
                count <= count + push_cnt - pop_cnt;
            end
        end
    end

    // Halfword storage; a skipped low half writes only the upper half at tail.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FQ_DEPTH; i++) fq_mem[i] <= '0;
        end else if (push_en) begin
            if (skip_lo) begin
                fq_mem[tail] <= ICACHE_rdata[31:16];
            end else begin
                fq_mem[tail]     <= ICACHE_rdata[15:0];
                fq_mem[tail_nxt] <= ICACHE_rdata[31:16];
            end
        end
    end

endmodule
